// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, common command bytes
// and the odd-parity helper used when framing a byte.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        ACK,
        WAIT_IDLE,
        FAIL
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    // Parity bit that makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Processor-side command interface of the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_error
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers and falling-edge detectors for the PS2_CLK and
// PS2_DAT lines; shared with the receive path.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fe,
    output logic dat_fe
);

    logic clk_m, dat_m;
    logic clk_d, dat_d;

    // Idle lines are high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_m <= 1'b1;
            clk_s <= 1'b1;
            clk_d <= 1'b1;
            dat_m <= 1'b1;
            dat_s <= 1'b1;
            dat_d <= 1'b1;
        end else begin
            clk_m <= clk_in;
            clk_s <= clk_m;
            clk_d <= clk_s;
            dat_m <= dat_in;
            dat_s <= dat_m;
            dat_d <= dat_s;
        end
    end

    assign clk_fe = clk_d & ~clk_s;
    assign dat_fe = dat_d & ~dat_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits LSB first, odd
// parity, stop, then device ack check. Define PS2_TX_RETRY_EN for one retry.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 1200,
    parameter int START_TIMEOUT_CYCLES = 150000,
    parameter int XFER_TIMEOUT_CYCLES  = 20000
) (
    input  logic          clock,
    input  logic          reset,
    ps2_host_tx_if.slave  cmd,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);

    localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                               INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > XFER_TIMEOUT_CYCLES) ?
                               CNT_MAX_A : XFER_TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t INH_LAST   = cnt_t'(INHIBIT_CYCLES - 1);
    localparam cnt_t INH_PRE    = cnt_t'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic INH_SHORT  = (INHIBIT_CYCLES < 2);
    localparam cnt_t START_LAST = cnt_t'(START_TIMEOUT_CYCLES - 1);
    localparam cnt_t XFER_LAST  = cnt_t'(XFER_TIMEOUT_CYCLES - 1);
    localparam cnt_t CNT_TOP    = cnt_t'(CNT_MAX);

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_TOP) ? c : c + cnt_t'(1);
    endfunction

    ps2_state_t state;
    cnt_t       cnt;
    logic [2:0] idx;
    logic [7:0] sh;
    logic       par;
    logic       last_try;

    logic clk_s, dat_s, clk_fe, dat_fe;

    ps2_line_sync u_sync (
        .clock  (clock),
        .reset  (reset),
        .clk_in (ps2_clk_in),
        .dat_in (ps2_dat_in),
        .clk_s  (clk_s),
        .dat_s  (dat_s),
        .clk_fe (clk_fe),
        .dat_fe (dat_fe)
    );

    logic timeout, nack;
    assign timeout = ((state == START) && (cnt >= START_LAST)) ||
                     ((state inside {DATA, PARITY, ACK, WAIT_IDLE}) && (cnt >= XFER_LAST));
    assign nack    = (state == ACK) && clk_fe && dat_s;

`ifdef PS2_TX_RETRY_EN
    logic retried;
    assign last_try = retried;
`else
    assign last_try = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            ps2_clk_oe   <= 1'b0;
            ps2_dat_oe   <= 1'b0;
            cmd.tx_ready <= 1'b1;
            cmd.tx_busy  <= 1'b0;
            cmd.tx_done  <= 1'b0;
            cmd.tx_error <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried      <= 1'b0;
`endif
        end else begin
            cmd.tx_done  <= 1'b0;
            cmd.tx_error <= 1'b0;
            // A timeout takes priority over any edge arriving in the same cycle.
            if (timeout || nack) begin
                state        <= FAIL;
                cnt          <= '0;
                ps2_clk_oe   <= 1'b0;
                ps2_dat_oe   <= 1'b0;
                cmd.tx_error <= last_try;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd.tx_valid) begin
                            sh           <= cmd.tx_data;
                            par          <= odd_parity(cmd.tx_data);
                            cnt          <= '0;
                            ps2_clk_oe   <= 1'b1;
                            ps2_dat_oe   <= INH_SHORT;
                            cmd.tx_ready <= 1'b0;
                            cmd.tx_busy  <= 1'b1;
                            state        <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        cnt <= sat_inc(cnt);
                        // Start bit goes on the wire during the last inhibit cycle.
                        if (cnt == INH_PRE) ps2_dat_oe <= 1'b1;
                        if (cnt == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            ps2_dat_oe <= 1'b1;
                            cnt        <= '0;
                            state      <= START;
                        end
                    end
                    START: begin
                        if (clk_fe) begin
                            ps2_dat_oe <= ~sh[0];
                            idx        <= '0;
                            cnt        <= '0;
                            state      <= DATA;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    DATA: begin
                        cnt <= sat_inc(cnt);
                        if (clk_fe) begin
                            if (idx == 3'd7) begin
                                ps2_dat_oe <= ~par;
                                state      <= PARITY;
                            end else begin
                                idx        <= idx + 3'd1;
                                sh         <= sh >> 1;
                                ps2_dat_oe <= ~sh[1];
                            end
                        end
                    end
                    PARITY: begin
                        cnt <= sat_inc(cnt);
                        if (clk_fe) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= ACK;
                        end
                    end
                    ACK: begin
                        cnt <= sat_inc(cnt);
                        if (clk_fe) state <= WAIT_IDLE;
                    end
                    WAIT_IDLE: begin
                        cnt <= sat_inc(cnt);
                        if (clk_s && dat_s) begin
                            cmd.tx_done  <= 1'b1;
                            cmd.tx_ready <= 1'b1;
                            cmd.tx_busy  <= 1'b0;
                            cnt          <= '0;
                            state        <= IDLE;
`ifdef PS2_TX_RETRY_EN
                            retried      <= 1'b0;
`endif
                        end
                    end
                    FAIL: begin
`ifdef PS2_TX_RETRY_EN
                        if (!retried) begin
                            retried    <= 1'b1;
                            cnt        <= '0;
                            ps2_clk_oe <= 1'b1;
                            ps2_dat_oe <= INH_SHORT;
                            state      <= INHIBIT;
                        end else begin
                            retried      <= 1'b0;
                            cmd.tx_ready <= 1'b1;
                            cmd.tx_busy  <= 1'b0;
                            state        <= IDLE;
                        end
`else
                        cmd.tx_ready <= 1'b1;
                        cmd.tx_busy  <= 1'b0;
                        state        <= IDLE;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out while a
// scoreboard of expected wire bits is filled at send time and drained per edge.
module tb_ps2_host_tx;

    localparam int N = 40;
    localparam int T = 1500;
    localparam int X = 1500;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ps2_host_tx_if cmd_if ();

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic ps2_clk_oe, ps2_dat_oe;
    logic ps2_clk_in, ps2_dat_in;
    assign ps2_clk_in = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (N),
        .START_TIMEOUT_CYCLES (T),
        .XFER_TIMEOUT_CYCLES  (X)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd        (cmd_if.slave),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    int  n_pass   = 0;
    int  n_checks = 0;
    int  done_cnt = 0;
    int  err_cnt  = 0;
    logic exp_q[$];

    always @(negedge clock) begin
        if (cmd_if.tx_done)  done_cnt++;
        if (cmd_if.tx_error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        @(negedge clock);
        while (!cmd_if.tx_ready && g < 5000) begin
            @(negedge clock);
            g++;
        end
        check("ready_before_send", cmd_if.tx_ready, 1'b1);
        cmd_if.tx_data  = b;
        cmd_if.tx_valid = 1'b1;
        @(posedge clock);
        #1 cmd_if.tx_valid = 1'b0;
        push_frame(b);
    endtask

    task automatic check_inhibit(input string tag);
        int n;
        n = 0;
        while (ps2_clk_oe && n < 10 * N) begin
            @(negedge clock);
            if (ps2_clk_oe) n++;
        end
        check(tag, n, N);
    endtask

    task automatic dev_run(input int n_fe, input bit ack);
        int g;
        logic e;
        g = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && g < 1000) begin
            @(negedge clock);
            g++;
        end
        check("start_cond", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        for (int k = 0; k < n_fe; k++) begin
            repeat (10) @(negedge clock);
            if (k == 10) dev_dat_low = ack;
            repeat (10) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clock);
            if (k < 10) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                check($sformatf("wire_bit%0d", k), ps2_dat_in, e);
            end
            dev_clk_low = 1'b0;
            if (k == 10) begin
                repeat (5) @(negedge clock);
                dev_dat_low = 1'b0;
            end
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int g;
        g = 0;
        while (done_cnt == d0 && err_cnt == e0 && g < 4 * X) begin
            @(negedge clock);
            g++;
        end
        repeat (5) @(negedge clock);
    endtask

    task automatic good_xfer(input logic [7:0] b, input string tag);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        check({tag, "_inhibit"}, 0, 0);
        n_checks--;
        n_pass--;
        check_inhibit({tag, "_inhibit"});
        dev_run(11, 1'b1);
        wait_outcome(d0, e0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_err_pulses"}, err_cnt - e0, 0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0, e0, t, lo, hi, attempts, busy_seen;
        cmd_if.tx_data  = 8'h00;
        cmd_if.tx_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rst_ready", cmd_if.tx_ready, 1'b1);
        check("rst_busy",  cmd_if.tx_busy,  1'b0);
        check("rst_done",  cmd_if.tx_done,  1'b0);
        check("rst_error", cmd_if.tx_error, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_dat_oe", ps2_dat_oe, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        good_xfer(8'hED, "ed");
        good_xfer(8'hF4, "f4");

        // Device never clocks.
`ifdef PS2_TX_RETRY_EN
        attempts = 2;
`else
        attempts = 1;
`endif
        d0 = done_cnt;
        send(8'hF4);
        exp_q.delete();
        t = 0;
        while (!cmd_if.tx_error && t < 4 * (N + T) * attempts) begin
            @(negedge clock);
            t++;
        end
        lo = attempts * (N + T) - 1;
        hi = attempts * (N + T) + 4;
        check("noclk_err_latency_in_window", (t >= lo && t <= hi), 1'b1);
        check("noclk_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        @(negedge clock);
        check("noclk_ready_after", cmd_if.tx_ready, 1'b1);
        check("noclk_no_done", done_cnt - d0, 0);

        // Device leaves data high at the ack edge.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        check_inhibit("nack_inhibit");
        dev_run(11, 1'b0);
        if (attempts == 2) begin
            push_frame(8'hED);
            dev_run(11, 1'b0);
        end
        wait_outcome(d0, e0);
        check("nack_err_pulses", err_cnt - e0, 1);
        check("nack_done_pulses", done_cnt - d0, 0);
        check("nack_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);

        // Reset in the middle of the data bits.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        check_inhibit("rstmid_inhibit");
        dev_run(4, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rstmid_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("rstmid_ready", cmd_if.tx_ready, 1'b1);
        check("rstmid_busy", cmd_if.tx_busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        repeat (30) @(negedge clock);
        check("rstmid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // A request while busy is dropped, not queued.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        fork
            dev_run(11, 1'b1);
            begin
                repeat (150) @(negedge clock);
                check("busy_during_xfer", cmd_if.tx_busy, 1'b1);
                cmd_if.tx_data  = 8'h55;
                cmd_if.tx_valid = 1'b1;
                @(negedge clock);
                cmd_if.tx_valid = 1'b0;
            end
        join
        wait_outcome(d0, e0);
        check("ignore_done_pulses", done_cnt - d0, 1);
        busy_seen = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clock);
            if (cmd_if.tx_busy || ps2_clk_oe) busy_seen++;
        end
        check("ignore_no_second_xfer", busy_seen, 0);
        check("ignore_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable, over the same open-collector PS2_CLK/PS2_DAT pair the receive path listens on.
- It takes a byte from the processor-side command interface, frames it as start, 8 data bits LSB first, odd parity and stop, then checks the device's ack bit.
- It runs on the processor clock, nominally 10 MHz from the PLL.
- The top level turns each `_oe` output into an open-drain low driver; the lines are pulled up when released.

Parameters:
- INHIBIT_CYCLES, default 1200: clock cycles PS2_CLK is held low before the start bit (120 us at 10 MHz).
- START_TIMEOUT_CYCLES, default 150000: maximum wait, after releasing the clock, for the device's first falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, default 20000: maximum time from the first falling edge to the ack edge (2 ms).

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- tx_data, input, 8: command byte to send.
- tx_valid, input, 1: request strobe; sampled only when tx_ready=1.
- tx_ready, output, 1: high in IDLE; the block accepts a new byte.
- tx_busy, output, 1: high whenever not in IDLE; the receive path ignores the bus while this is high.
- tx_done, output, 1: one-cycle pulse, byte sent and ack seen.
- tx_error, output, 1: one-cycle pulse, timeout or missing ack.
- ps2_clk_in, input, 1: raw PS2_CLK line level (asynchronous).
- ps2_dat_in, input, 1: raw PS2_DAT line level (asynchronous).
- ps2_clk_oe, output, 1: 1 = drive PS2_CLK low.
- ps2_dat_oe, output, 1: 1 = drive PS2_DAT low.

Behaviour:
- Line inputs: two-flop synchronizers on both lines. A falling edge (fe) is registered sync value 1 followed by 0. fe is seen 3 cycles after the pin edge.
- Reset values: tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, ps2_clk_oe=0, ps2_dat_oe=0. State is IDLE and all counters are 0.
- Reset mid-transfer releases both lines on the next clock edge; no done or error pulse is produced.
- IDLE:
  - On tx_valid, latch tx_data into a shift register and compute parity = ~^tx_data. Go to INHIBIT in the next cycle.
  - tx_valid while not in IDLE is ignored; no queueing.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. In the last cycle ps2_dat_oe is set to 1 (start bit = 0). Then go to START.
- START:
  - ps2_clk_oe=0 and ps2_dat_oe=1.
  - Wait for fe. On fe: ps2_dat_oe=~bit0, bit index=0, go to DATA, clear the timeout counter.
  - If START_TIMEOUT_CYCLES elapse with no fe, go to FAIL.
- DATA: on each fe, advance the index and drive the next bit (ps2_dat_oe = ~bit). On the fe after bit7 is presented, drive ~parity and go to PARITY.
- PARITY: on fe, ps2_dat_oe=0 (stop bit = 1, line released), go to ACK.
- ACK: on fe, sample synchronized data.
  - 0: device acked, go to WAIT_IDLE.
  - 1: no ack, go to FAIL.
- WAIT_IDLE: wait until both synchronized lines are high, then pulse tx_done, go to IDLE.
- XFER timeout: a counter runs in DATA, PARITY, ACK and WAIT_IDLE. Reaching XFER_TIMEOUT_CYCLES goes to FAIL.
- FAIL: release both lines, pulse tx_error for one cycle, go to IDLE.
- Total fe edges consumed per byte: 11 (start-acknowledge, 8 data, parity, ack).
- Counters are wide enough for the largest parameter: clog2(max+1) bits. They saturate and never wrap.
- A timeout and an fe in the same cycle: the timeout wins.
- tx_ready and tx_done can be high in the same cycle only at the IDLE entry cycle. A new tx_valid in that cycle is accepted.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On the first FAIL the block suppresses tx_error and re-enters INHIBIT with the same latched byte.
  - A second failure pulses tx_error.
  - A retry flag clears on IDLE entry and on reset.
  - tx_busy stays high across the retry.
- Undefined: a single attempt only; FAIL always pulses tx_error.

Decomposition:
- Shared package ps2_pkg:
  - State enum (IDLE, INHIBIT, START, DATA, PARITY, ACK, WAIT_IDLE, FAIL).
  - Command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_ACK_BYTE=8'hFA.
  - Odd-parity function.
- Sub-module ps2_line_sync: synchronizers plus falling-edge detect for both lines. It is reusable by the receive path.

Test Plan:
- Send 0xED, device model acks:
  - Clock is held low for 1200 cycles.
  - Bits on the wire, LSB first: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_error stays 0.
- Send 0xF4 with ack: data bits 0,0,1,0,1,1,1,1, parity 0; tx_done pulses.
- Device never clocks:
  - tx_error pulses at exactly 1200+150000 cycles (± sync latency) after the request.
  - Lines are released.
  - With PS2_TX_RETRY_EN defined, tx_error comes only after the second 151200-cycle attempt.
- Device leaves data high at the ack edge: tx_error pulses, tx_done stays 0, both oe outputs are 0 afterwards.
- reset asserted mid-DATA (after bit3): ps2_clk_oe and ps2_dat_oe are 0 the next cycle, tx_ready=1, no pulses.
- tx_valid with 0x55 asserted during a transfer of 0xED: the wire shows only 0xED, and 0x55 is never sent.
